// File: rtl/seq_signed_divider_if.sv
// Operand/result handshake bundle for seq_signed_divider.
// The master drives the operands and out_ready; the slave is the divider itself.
interface seq_signed_divider_if #(parameter int WIDTH = 16);
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] dividend;
    logic [WIDTH-1:0]   divisor;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic               err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, err
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Restoring shift-subtract signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Define DIV_ERR_CHECK_EN to flag divide-by-zero/overflow on err and take the early exit from PREP.
module seq_signed_divider #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    seq_signed_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t state;
    state_t next_state;

    logic [2*WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0]   dsr_q;
    logic [WIDTH-1:0]   abs_dsr;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   lo;
    logic [CW-1:0]      count;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;

    // Magnitudes read as unsigned, so the most-negative operands map to 2^(n-1) without wrapping.
    logic [2*WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0]   abs_dsr_c;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               q_bit;
    logic               early_err;
    logic               fix_err;

    assign abs_dvd   = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
    assign abs_dsr_c = dsr_q[WIDTH-1] ? -dsr_q : dsr_q;
    assign rem_sh    = {rem, lo[WIDTH-1]};
    assign trial     = {1'b0, rem_sh} - {2'b00, abs_dsr};
    assign q_bit     = ~trial[WIDTH+1];

`ifdef DIV_ERR_CHECK_EN
    logic err_q;

    assign early_err = (abs_dsr_c == '0) || (abs_dvd[2*WIDTH-1:WIDTH] >= abs_dsr_c);
    assign fix_err   = neg_q ? (lo[WIDTH-1] && (|lo[WIDTH-2:0])) : lo[WIDTH-1];
    assign bus.err   = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state == PREP && early_err) begin
            err_q <= 1'b1;
        end else if (state == FIX) begin
            err_q <= fix_err;
        end
    end
`else
    assign early_err = 1'b0;
    assign fix_err   = 1'b0;
    assign bus.err   = 1'b0;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid) next_state = PREP;
            PREP:    next_state = early_err ? DONE : CALC;
            CALC:    if (count == LAST) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // lo starts as the low dividend half and fills with quotient bits as it shifts out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dvd_q       <= '0;
            dsr_q       <= '0;
            abs_dsr     <= '0;
            rem         <= '0;
            lo          <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dvd_q <= bus.dividend;
                        dsr_q <= bus.divisor;
                    end
                end
                PREP: begin
                    neg_q   <= dvd_q[2*WIDTH-1] ^ dsr_q[WIDTH-1];
                    neg_r   <= dvd_q[2*WIDTH-1];
                    abs_dsr <= abs_dsr_c;
                    rem     <= abs_dvd[2*WIDTH-1:WIDTH];
                    lo      <= abs_dvd[WIDTH-1:0];
                    count   <= '0;
                    if (early_err) begin
                        quotient_q  <= '0;
                        remainder_q <= '0;
                    end
                end
                CALC: begin
                    rem   <= q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    lo    <= {lo[WIDTH-2:0], q_bit};
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (fix_err) begin
                        quotient_q  <= '0;
                        remainder_q <= '0;
                    end else begin
                        quotient_q  <= neg_q ? -lo : lo;
                        remainder_q <= neg_r ? -rem : rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed-vector bench for seq_signed_divider at WIDTH=16, with extra vectors when DIV_ERR_CHECK_EN is defined.
module tb_seq_signed_divider;
    localparam int WIDTH = 16;
    localparam int FULL_LAT = WIDTH + 2;

    typedef struct {
        logic [31:0] dvd;
        logic [15:0] dsr;
        logic [15:0] q;
        logic [15:0] r;
        logic        e;
        logic        early;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    seq_signed_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_signed_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [31:0] dvd, input logic [15:0] dsr,
                                input logic [15:0] q, input logic [15:0] r,
                                input logic e, input logic early);
        vec_t v;
        v.dvd = dvd; v.dsr = dsr; v.q = q; v.r = r; v.e = e; v.early = early;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Issues one operation and returns the number of edges from accept to out_valid.
    task automatic applyStimulus(input logic [31:0] dvd, input logic [15:0] dsr, output int lat);
        int waited;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dsr;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = 32'hDEAD_BEEF;
        bus.divisor  = 16'hA5A5;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic takeResult();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("out_valid_after_take", 32'(bus.out_valid), 32'd0);
        checkOutput("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [15:0] held_q;
        logic [15:0] held_r;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("reset_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("reset_err", 32'(bus.err), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 1'b0));
        vecs.push_back(mk(-32'sd100,      16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 1'b0));
        vecs.push_back(mk(32'd100,        -16'sd7,    16'hFFF2,   16'd2,      1'b0, 1'b0));
        vecs.push_back(mk(-32'sd100,      -16'sd7,    16'd14,     16'hFFFE,   1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_8000,  16'd1,      16'h8000,   16'd0,      1'b0, 1'b0));
        vecs.push_back(mk(32'd1000,       -16'sd3,    16'hFEB3,   16'd1,      1'b0, 1'b0));
        vecs.push_back(mk(32'h3FFF_0000,  16'h7FFF,   16'd32766,  16'd32766,  1'b0, 1'b0));
        vecs.push_back(mk(32'd0,          16'd5,      16'd0,      16'd0,      1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFF,  16'd2,      16'd0,      16'hFFFF,   1'b0, 1'b0));
        vecs.push_back(mk(32'd12345678,   -16'sd1234, 16'hD8EC,   16'd742,    1'b0, 1'b0));
        vecs.push_back(mk(32'h0001_0000,  16'h8000,   16'hFFFE,   16'd0,      1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_0001,  16'h8000,   16'd1,      16'h8001,   1'b0, 1'b0));
        vecs.push_back(mk(32'h4000_0000,  16'h8000,   16'h8000,   16'd0,      1'b0, 1'b0));
`ifdef DIV_ERR_CHECK_EN
        vecs.push_back(mk(32'hFFFF_8000,  16'hFFFF,   16'd0,      16'd0,      1'b1, 1'b0));
        vecs.push_back(mk(32'h1234_5678,  16'd0,      16'd0,      16'd0,      1'b1, 1'b1));
        vecs.push_back(mk(32'h7FFF_0000,  16'd1,      16'd0,      16'd0,      1'b1, 1'b1));
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dvd, vecs[i].dsr, lat);
            if (vecs[i].early)
                checkOutput($sformatf("latency_early[%0d]", i), 32'(lat <= 2), 32'd1);
            else
                checkOutput($sformatf("latency[%0d]", i), 32'(lat), 32'(FULL_LAT));
            checkOutput($sformatf("out_valid[%0d]", i), 32'(bus.out_valid), 32'd1);
            checkOutput($sformatf("in_ready_busy[%0d]", i), 32'(bus.in_ready), 32'd0);
            checkOutput($sformatf("err[%0d]", i), 32'(bus.err), 32'(vecs[i].e));
            checkOutput($sformatf("quotient[%0d]", i), 32'(bus.quotient), 32'(vecs[i].q));
            checkOutput($sformatf("remainder[%0d]", i), 32'(bus.remainder), 32'(vecs[i].r));
            takeResult();
        end

        // Result held for 10 cycles with out_ready low, then a back-to-back operation.
        applyStimulus(32'd50000, 16'd123, lat);
        checkOutput("hold_latency", 32'(lat), 32'(FULL_LAT));
        held_q = bus.quotient;
        held_r = bus.remainder;
        checkOutput("hold_quotient", 32'(held_q), 32'd406);
        checkOutput("hold_remainder", 32'(held_r), 32'd62);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold_q_stable", 32'(bus.quotient), 32'd406);
            checkOutput("hold_r_stable", 32'(bus.remainder), 32'd62);
        end
        takeResult();
        applyStimulus(-32'sd1000, 16'd3, lat);
        checkOutput("b2b_latency", 32'(lat), 32'(FULL_LAT));
        checkOutput("b2b_quotient", 32'(bus.quotient), 32'hFEB3);
        checkOutput("b2b_remainder", 32'(bus.remainder), 32'hFFFF);
        takeResult();

        // Reset dropped while CALC is at count=7 (eight edges after accept).
        bus.in_valid = 1'b1;
        bus.dividend = 32'd77777;
        bus.divisor  = 16'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("mid_busy_in_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_quotient", 32'(bus.quotient), 32'd0);
        checkOutput("abort_remainder", 32'(bus.remainder), 32'd0);
        checkOutput("abort_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'd1000, -16'sd3, lat);
        checkOutput("post_reset_latency", 32'(lat), 32'(FULL_LAT));
        checkOutput("post_reset_quotient", 32'(bus.quotient), 32'hFEB3);
        checkOutput("post_reset_remainder", 32'(bus.remainder), 32'd1);
        checkOutput("post_reset_err", 32'(bus.err), 32'd0);
        takeResult();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
